// File: rtl/vector_register_file.sv
// SIMD vector register file: 2 comb read ports, lane-masked write, beat loader.
// Optional VRF_BYPASS_EN macro forwards in-flight writes to the read ports.
module vector_register_file #(
    parameter int NREGS  = 16,
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int BEAT_W = 8,
    localparam int VEC_W  = LANES * LANE_W,
    localparam int ADDR_W = $clog2(NREGS),
    localparam int BEATS  = VEC_W / BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_lane_mask,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [VEC_W-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [VEC_W-1:0]  rd_data_b,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_valid,
    input  logic [BEAT_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ld_tgt;
    logic [VEC_W-1:0]  shadow;
    logic [VEC_W-1:0]  regs [NREGS];
    logic              commit;

    assign commit   = (state == COMMIT);
    assign ld_ready = (state == RECV);
    assign ld_busy  = (state != IDLE);
    assign ld_done  = commit;

    // Loader sequencer: capture target, gather beats MSB-first, then commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ld_tgt <= '0;
            shadow <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ld_start) begin
                        state  <= RECV;
                        ld_tgt <= ld_addr;
                        cnt    <= '0;
                    end
                end
                RECV: begin
                    if (ld_valid) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (cnt == CNT_W'(k))
                                shadow[VEC_W-1-k*BEAT_W -: BEAT_W] <= ld_data;
                        end
                        if (cnt == CNT_W'(BEATS - 1))
                            state <= COMMIT;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array update on the falling edge; the mask is MSB-aligned with the
    // data (mask[LANES-1] gates lane 0) and core lanes override the commit
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_en && int'(wr_addr) == r
                        && wr_lane_mask[LANES-1-l])
                        regs[r][VEC_W-1-l*LANE_W -: LANE_W]
                            <= wr_data[VEC_W-1-l*LANE_W -: LANE_W];
                    else if (commit && int'(ld_tgt) == r)
                        regs[r][VEC_W-1-l*LANE_W -: LANE_W]
                            <= shadow[VEC_W-1-l*LANE_W -: LANE_W];
                end
            end
        end
    end

    // Read port A: array lookup, optionally overlaid with in-flight writes
    always_comb begin
        rd_data_a = '0;
        if (int'(rd_addr_a) < NREGS) begin
            rd_data_a = regs[rd_addr_a];
`ifdef VRF_BYPASS_EN
            for (int l = 0; l < LANES; l++) begin
                if (wr_en && wr_addr == rd_addr_a
                    && wr_lane_mask[LANES-1-l])
                    rd_data_a[VEC_W-1-l*LANE_W -: LANE_W]
                        = wr_data[VEC_W-1-l*LANE_W -: LANE_W];
                else if (commit && ld_tgt == rd_addr_a)
                    rd_data_a[VEC_W-1-l*LANE_W -: LANE_W]
                        = shadow[VEC_W-1-l*LANE_W -: LANE_W];
            end
`endif
        end
    end

    // Read port B: same as port A
    always_comb begin
        rd_data_b = '0;
        if (int'(rd_addr_b) < NREGS) begin
            rd_data_b = regs[rd_addr_b];
`ifdef VRF_BYPASS_EN
            for (int l = 0; l < LANES; l++) begin
                if (wr_en && wr_addr == rd_addr_b
                    && wr_lane_mask[LANES-1-l])
                    rd_data_b[VEC_W-1-l*LANE_W -: LANE_W]
                        = wr_data[VEC_W-1-l*LANE_W -: LANE_W];
                else if (commit && ld_tgt == rd_addr_b)
                    rd_data_b[VEC_W-1-l*LANE_W -: LANE_W]
                        = shadow[VEC_W-1-l*LANE_W -: LANE_W];
            end
`endif
        end
    end

endmodule
